// File: rtl/alkqreg.sv
// Q register, Q shifter and multiply/divide iteration counter for the ALK/DPM datapath.
// Q is built from per-bit cells; the shift-out taps read only registered Q, never q_sin_h.

module alkqreg_qbit (
    input  logic clk,
    input  logic reset_h,
    input  logic load,
    input  logic shl,
    input  logic shr,
    input  logic in_range,
    input  logic d_load,
    input  logic d_lo,
    input  logic d_hi,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset_h)
            q <= 1'b0;
        else if (load)
            q <= d_load;
        else if (shl && in_range)
            q <= d_lo;
        else if (shr && in_range)
            q <= d_hi;
    end
endmodule

module alkqreg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_h,
    input  logic             dq_q_load_h,
    input  logic             dq_q_shl_h,
    input  logic             dq_q_shr_h,
    input  logic [1:0]       dl_size_h,
    input  logic [WIDTH-1:0] wbus_in_h,
    input  logic             q_sin_h,
    input  logic             loop_start_h,
    input  logic [CNT_W-1:0] loop_count_h,
    input  logic             loop_step_h,
    output logic [WIDTH-1:0] q_h,
    output logic             q_sout_shl_h,
    output logic             q_sout_shr_h,
    output logic             loopf_h,
    output logic             loop_done_h
);
    logic sz_byte, sz_word, sz_long;
    logic shl_en, shr_en;

    always_comb begin
        sz_byte = (dl_size_h == 2'b00);
        sz_word = (dl_size_h == 2'b01);
        sz_long = dl_size_h[1];
        // both shift bits together is illegal and must leave Q untouched
        shl_en  = dq_q_shl_h && !dq_q_shr_h;
        shr_en  = dq_q_shr_h && !dq_q_shl_h;
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_q
            logic in_range, is_top, d_lo, d_hi;

            always_comb begin
                in_range = sz_long || (sz_word && (i < 16)) || (sz_byte && (i < 8));
                is_top   = (sz_long && (i == WIDTH-1)) || (sz_word && (i == 15)) ||
                           (sz_byte && (i == 7));
            end

            if (i == 0) begin : g_lo0
                assign d_lo = q_sin_h;
            end else begin : g_lon
                assign d_lo = q_h[i-1];
            end

            if (i == WIDTH-1) begin : g_hitop
                assign d_hi = q_sin_h;
            end else begin : g_hin
                assign d_hi = is_top ? q_sin_h : q_h[i+1];
            end

            alkqreg_qbit u_bit (
                .clk      (clk),
                .reset_h  (reset_h),
                .load     (dq_q_load_h),
                .shl      (shl_en),
                .shr      (shr_en),
                .in_range (in_range),
                .d_load   (wbus_in_h[i]),
                .d_lo     (d_lo),
                .d_hi     (d_hi),
                .q        (q_h[i])
            );
        end
    endgenerate

    always_comb begin
        q_sout_shl_h = sz_byte ? q_h[7] : sz_word ? q_h[15] : q_h[WIDTH-1];
        q_sout_shr_h = q_h[0];
    end

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset_h) begin
            cnt         <= '0;
            loop_done_h <= 1'b0;
        end else if (loop_start_h) begin
            cnt         <= loop_count_h;
            loop_done_h <= 1'b0;
        end else if (loop_step_h && cnt != '0) begin
            cnt         <= cnt - 1'b1;
            loop_done_h <= (cnt == CNT_W'(1));
        end else begin
            loop_done_h <= 1'b0;
        end
    end

    assign loopf_h = (cnt != '0);
endmodule

// File: tb/tb_alkqreg.sv
// Directed testbench for alkqreg: Q load/shift/hold, shift-out taps and loop counter.

module tb_alkqreg;
    logic        clk = 1'b0;
    logic        reset_h, dq_q_load_h, dq_q_shl_h, dq_q_shr_h;
    logic [1:0]  dl_size_h;
    logic [31:0] wbus_in_h;
    logic        q_sin_h, loop_start_h, loop_step_h;
    logic [5:0]  loop_count_h;
    logic [31:0] q_h;
    logic        q_sout_shl_h, q_sout_shr_h, loopf_h, loop_done_h;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alkqreg dut (
        .clk          (clk),
        .reset_h      (reset_h),
        .dq_q_load_h  (dq_q_load_h),
        .dq_q_shl_h   (dq_q_shl_h),
        .dq_q_shr_h   (dq_q_shr_h),
        .dl_size_h    (dl_size_h),
        .wbus_in_h    (wbus_in_h),
        .q_sin_h      (q_sin_h),
        .loop_start_h (loop_start_h),
        .loop_count_h (loop_count_h),
        .loop_step_h  (loop_step_h),
        .q_h          (q_h),
        .q_sout_shl_h (q_sout_shl_h),
        .q_sout_shr_h (q_sout_shr_h),
        .loopf_h      (loopf_h),
        .loop_done_h  (loop_done_h)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset_h = 0; dq_q_load_h = 0; dq_q_shl_h = 0; dq_q_shr_h = 0;
        q_sin_h = 0; loop_start_h = 0; loop_step_h = 0; loop_count_h = '0;
    endtask

    task automatic load_q(input logic [31:0] v, input logic [1:0] sz);
        idle();
        dl_size_h = sz; wbus_in_h = v; dq_q_load_h = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle(); dl_size_h = 2'b10; wbus_in_h = 32'hDEAD_BEEF;
        reset_h = 1; loop_start_h = 1; loop_count_h = 6'd7; dq_q_load_h = 1;
        tick(); idle();
        checks++; if (q_h !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q_h); end
        checks++; if (loopf_h !== 1'b0 || loop_done_h !== 1'b0) begin errors++;
            $display("FAIL reset_loop got loopf=%b done=%b exp 0 0", loopf_h, loop_done_h); end
    endtask

    task automatic test_load_long();
        load_q(32'h8000_0001, 2'b10);
        checks++; if (q_h !== 32'h8000_0001) begin errors++; $display("FAIL load_long got=%h exp=80000001", q_h); end
        checks++; if (q_sout_shl_h !== 1'b1 || q_sout_shr_h !== 1'b1) begin errors++;
            $display("FAIL sout_long got shl=%b shr=%b exp 1 1", q_sout_shl_h, q_sout_shr_h); end
    endtask

    task automatic test_reset_mid_loop();
        idle(); loop_start_h = 1; loop_count_h = 6'd3; tick();
        idle(); loop_step_h = 1; tick();
        tick();
        // counter is now 1: a step alongside reset must not produce a done pulse
        checks++; if (loopf_h !== 1'b1) begin errors++; $display("FAIL pre_reset_loopf got=%b exp=1", loopf_h); end
        reset_h = 1; tick(); idle();
        checks++; if (q_h !== 32'h0 || loopf_h !== 1'b0 || loop_done_h !== 1'b0) begin errors++;
            $display("FAIL reset_mid_loop got q=%h loopf=%b done=%b exp 0 0 0", q_h, loopf_h, loop_done_h); end
    endtask

    task automatic test_shift_right_byte();
        load_q(32'h1234_5681, 2'b00);
        checks++; if (q_sout_shr_h !== 1'b1) begin errors++; $display("FAIL shr_byte_pre got=%b exp=1", q_sout_shr_h); end
        dq_q_shr_h = 1; q_sin_h = 1;
        checks++; if (q_sout_shr_h !== 1'b1) begin errors++; $display("FAIL shr_no_sin_path got=%b exp=1", q_sout_shr_h); end
        tick(); idle();
        checks++; if (q_h !== 32'h1234_56C0) begin errors++; $display("FAIL shr_byte got=%h exp=123456c0", q_h); end
        checks++; if (q_sout_shr_h !== 1'b0 || q_sout_shl_h !== 1'b1) begin errors++;
            $display("FAIL shr_byte_sout got shl=%b shr=%b exp 1 0", q_sout_shl_h, q_sout_shr_h); end
    endtask

    task automatic test_shift_left_word();
        load_q(32'h0000_8000, 2'b01);
        checks++; if (q_sout_shl_h !== 1'b1) begin errors++; $display("FAIL shl_word_pre got=%b exp=1", q_sout_shl_h); end
        dq_q_shl_h = 1; q_sin_h = 0; tick(); idle();
        checks++; if (q_h !== 32'h0 || q_sout_shl_h !== 1'b0) begin errors++;
            $display("FAIL shl_word got q=%h shl=%b exp 0 0", q_h, q_sout_shl_h); end
        load_q(32'hABCD_C001, 2'b01);
        dq_q_shl_h = 1; q_sin_h = 1; tick(); idle();
        checks++; if (q_h !== 32'hABCD_8003) begin errors++; $display("FAIL shl_word_upper got=%h exp=abcd8003", q_h); end
        load_q(32'h4000_0000, 2'b10);
        checks++; if (q_sout_shl_h !== 1'b0) begin errors++; $display("FAIL shl_long_pre got=%b exp=0", q_sout_shl_h); end
        dl_size_h = 2'b11; dq_q_shl_h = 1; tick(); idle();
        checks++; if (q_h !== 32'h8000_0000 || q_sout_shl_h !== 1'b1) begin errors++;
            $display("FAIL shl_long got q=%h shl=%b exp 80000000 1", q_h, q_sout_shl_h); end
    endtask

    task automatic test_priority();
        load_q(32'hFFFF_FFFF, 2'b10);
        dq_q_shl_h = 1; dq_q_shr_h = 1; q_sin_h = 0; tick(); idle();
        checks++; if (q_h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL illegal_hold got=%h exp=ffffffff", q_h); end
        dq_q_load_h = 1; dq_q_shl_h = 1; wbus_in_h = 32'h0F0F_0F0F; tick(); idle();
        checks++; if (q_h !== 32'h0F0F_0F0F) begin errors++; $display("FAIL load_wins got=%h exp=0f0f0f0f", q_h); end
        tick();
        checks++; if (q_h !== 32'h0F0F_0F0F) begin errors++; $display("FAIL hold got=%h exp=0f0f0f0f", q_h); end
    endtask

    task automatic test_loop();
        int pulses;
        logic [3:0] exp_f;
        idle(); loop_start_h = 1; loop_count_h = 6'd3; tick();
        idle(); loop_step_h = 1;
        checks++; if (loopf_h !== 1'b1 || loop_done_h !== 1'b0) begin errors++;
            $display("FAIL loop_start got loopf=%b done=%b exp 1 0", loopf_h, loop_done_h); end
        exp_f = 4'b0011;   // loopf after steps 1..4 (LSB first)
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            dq_q_shr_h = (k == 0); dl_size_h = 2'b10; q_sin_h = 1;
            tick();
            if (loop_done_h) pulses++;
            checks++; if (loopf_h !== exp_f[k]) begin errors++;
                $display("FAIL loop_step%0d got loopf=%b exp=%b", k, loopf_h, exp_f[k]); end
            if (k == 0) begin
                checks++; if (q_h !== 32'h8787_8787) begin errors++;
                    $display("FAIL step_and_shift got=%h exp=87878787", q_h); end
            end
            if (k == 2) begin
                checks++; if (loop_done_h !== 1'b1) begin errors++; $display("FAIL loop_done got=%b exp=1", loop_done_h); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL loop_pulses got=%0d exp=1", pulses); end
        idle(); loop_start_h = 1; loop_count_h = 6'd0; tick(); idle();
        checks++; if (loopf_h !== 1'b0 || loop_done_h !== 1'b0) begin errors++;
            $display("FAIL start_zero got loopf=%b done=%b exp 0 0", loopf_h, loop_done_h); end
    endtask

    task automatic test_restart();
        int pulses;
        int cyc;
        idle(); loop_start_h = 1; loop_count_h = 6'd5; tick();
        idle(); loop_step_h = 1; tick(); tick(); tick();   // counter 2
        loop_start_h = 1; loop_count_h = 6'd5; tick();
        loop_start_h = 0;
        checks++; if (loopf_h !== 1'b1 || loop_done_h !== 1'b0) begin errors++;
            $display("FAIL restart got loopf=%b done=%b exp 1 0", loopf_h, loop_done_h); end
        pulses = 0; cyc = 0;
        while (loopf_h && cyc < 20) begin
            tick(); cyc++;
            if (loop_done_h) pulses++;
        end
        checks++; if (cyc != 5) begin errors++; $display("FAIL restart_len got=%0d exp=5", cyc); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL restart_pulses got=%0d exp=1", pulses); end
        tick(); idle();
        checks++; if (loopf_h !== 1'b0 || loop_done_h !== 1'b0) begin errors++;
            $display("FAIL step_at_zero got loopf=%b done=%b exp 0 0", loopf_h, loop_done_h); end
    endtask

    initial begin
        idle(); dl_size_h = 2'b10; wbus_in_h = '0;
        test_reset();
        test_load_long();
        test_reset_mid_loop();
        test_shift_right_byte();
        test_shift_left_word();
        test_priority();
        test_loop();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alkqreg.md
Name: alkqreg

Overview:
- Q register and Q shifter for the ALK/DPM datapath. Holds the 32-bit Q operand used by multiply, divide and double-length shift/rotate micro-ops.
- Consumes the Q shift-in bit produced by the Q shift-in multiplexer and produces the Q shift-out bits (left and right) that feed back into the ALU/Q shift routing.
- Also owns the multiply/divide iteration counter that generates LOOPF.

Parameters:
- WIDTH, 32, Q register width in bits. Fixed at 32 for VAX longword; byte and word sizing are done internally.
- CNT_W, 6, width of the iteration counter. Supports up to 63 steps.

Ports:
- clk  input  1  datapath clock; all state changes on the rising edge
- reset_h  input  1  synchronous active-high reset
- dq_q_load_h  input  1  DQ field: load Q from WBUS
- dq_q_shl_h  input  1  DQ field: shift Q left
- dq_q_shr_h  input  1  DQ field: shift Q right
- dl_size_h  input  2  data length: 00 byte, 01 word, 10/11 longword
- wbus_in_h  input  WIDTH  WBUS load data
- q_sin_h  input  1  Q shift-in bit from the shift-in multiplexer
- loop_start_h  input  1  load the iteration counter
- loop_count_h  input  CNT_W  iteration count to load
- loop_step_h  input  1  count one iteration
- q_h  output  WIDTH  current Q register contents
- q_sout_shl_h  output  1  Q bit shifted out on a left shift, which is Q[size-1]
- q_sout_shr_h  output  1  Q bit shifted out on a right shift, which is Q[0]
- loopf_h  output  1  loop flag: set while the counter is nonzero
- loop_done_h  output  1  one-cycle pulse when the counter reaches zero

Behaviour:
- Reset:
  - On a rising clk with reset_h=1: Q=0, counter=0, loopf_h=0, loop_done_h=0.
  - Reset overrides every other input, including in the middle of a loop.
- Q update priority per cycle is reset > load > shift > hold.
- Load: Q <= wbus_in_h, full WIDTH, independent of dl_size_h.
- Effective size N is 8, 16 or 32 from dl_size_h.
- Shift left: Q[N-1:0] <= {Q[N-2:0], q_sin_h}. Q[WIDTH-1:N] is unchanged.
- Shift right: Q[N-1:0] <= {q_sin_h, Q[N-1:1]}. Q[WIDTH-1:N] is unchanged.
- dq_q_shl_h and dq_q_shr_h both set is an illegal encoding: Q holds.
- Shift-out outputs:
  - q_sout_shl_h = Q[N-1] and q_sout_shr_h = Q[0], taken combinationally from the registered Q and the current dl_size_h.
  - There is no path from q_sin_h to these outputs. This breaks the feedback loop through the shift-in multiplexer.
- Shift latency is one cycle: the new Q and the new shift-out bits are visible after the edge.
- Iteration counter:
  - loop_start_h: counter <= loop_count_h. It takes priority over loop_step_h and restarts a running loop.
  - loop_step_h with counter != 0: counter <= counter - 1.
  - loop_step_h with counter = 0: no change, no wrap to all-ones.
  - loopf_h = (counter != 0), registered state, no combinational input path.
  - loop_done_h = 1 for exactly the cycle after a decrement from 1 to 0. It does not pulse for loop_start_h with count 0, or for a step at 0.
- Counter and Q are independent: a step and a shift in the same cycle both take effect.

Test Plan:
- Reset, then load 0x8000_0001 with size long -> q_h=0x8000_0001, q_sout_shl_h=1, q_sout_shr_h=1. Assert reset_h mid-loop -> q_h=0, loopf_h=0, no done pulse.
- Load 0x1234_5681, size byte, shift right with q_sin_h=1 -> q_h=0x1234_56C0, q_sout_shr_h=0, q_sout_shl_h=1.
- Load 0x0000_8000, size word, shift left with q_sin_h=0 -> q_h=0x0000_0000. Upper half is untouched; the shifted-out bit was reported on q_sout_shl_h=1 before the edge.
- Load 0xFFFF_FFFF; assert shl and shr together -> Q holds 0xFFFF_FFFF. Assert load and shl together -> load wins.
- loop_start with count 3, then step every cycle:
  - loopf_h=1 for 3 cycles, then 0.
  - loop_done_h pulses once.
  - A further step leaves the counter at 0.
  - loop_start with count 0 -> no pulse.
- Assert loop_start_h with count 5 mid-loop (counter=2) while stepping -> counter=5, no done pulse. The loop completes 5 steps later with a single pulse.
